// File: rtl/conv_3x3.sv
// Streaming 3x3 Sobel-Gx convolver: a two-line delay chain builds the window, and the output is |Gx| saturated to 8 bits.
// Pixel taps are exported for debug, along with the reg_00 column and a count of valid outputs.
module conv_3x3 #(
   parameter int W  = 220,
   parameter int H  = 220,
   parameter int DW = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [DW-1:0]   pxl_in,
   output logic [2*DW-1:0] reg_00,
   output logic [2*DW-1:0] reg_01,
   output logic [2*DW-1:0] reg_02,
   output logic [2*DW-1:0] sr_0,
   output logic [2*DW-1:0] reg_220,
   output logic [2*DW-1:0] reg_221,
   output logic [2*DW-1:0] reg_222,
   output logic [2*DW-1:0] sr_1,
   output logic [2*DW-1:0] reg_440,
   output logic [2*DW-1:0] reg_441,
   output logic [2*DW-1:0] reg_442,
   output logic [DW-1:0]   pxl_out,
   output logic            valid,
   output logic [7:0]      test,
   output logic [15:0]     test_valid
);

   localparam int DL = W - 3;
   localparam int CW = $clog2(W);
   localparam int RW = $clog2(H);
   localparam int SW = DW + 2;
   localparam int GW = DW + 3;

   logic [DW-1:0] t00, t01, t02, t220, t221, t222, t440, t441, t442;
   logic [DW-1:0] dl0 [DL];
   logic [DW-1:0] dl1 [DL];
   logic [CW-1:0] col, nxt_col;
   logic [RW-1:0] row, nxt_row;

   logic [SW-1:0]        pos_sum, neg_sum;
   logic signed [GW-1:0] gx;
   logic [GW-1:0]        gx_abs;
   logic [DW-1:0]        gx_sat;
   logic                 win_ok;

   // NOTE: the delay-line stages are ordinary flops, not a RAM. They are cleared with the rest of the state so the debug taps read zero after reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         t00  <= '0; t01  <= '0; t02  <= '0;
         t220 <= '0; t221 <= '0; t222 <= '0;
         t440 <= '0; t441 <= '0; t442 <= '0;
         for (int i = 0; i < DL; i++) begin
            dl0[i] <= '0;
            dl1[i] <= '0;
         end
      end else begin
         // NOTE: non-blocking assignments let every stage capture its predecessor's pre-edge value, whatever the statement order.
         t00    <= pxl_in;
         t01    <= t00;
         t02    <= t01;
         dl0[0] <= t02;
         for (int i = 1; i < DL; i++) dl0[i] <= dl0[i-1];
         t220   <= dl0[DL-1];
         t221   <= t220;
         t222   <= t221;
         dl1[0] <= t222;
         for (int i = 1; i < DL; i++) dl1[i] <= dl1[i-1];
         t440   <= dl1[DL-1];
         t441   <= t440;
         t442   <= t441;
      end
   end

   // The nxt_* counters hold the position of the next pixel to be sampled.
   // row/col therefore describe the pixel that has just entered reg_00.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         col     <= '0;
         row     <= '0;
         nxt_col <= '0;
         nxt_row <= '0;
      end else begin
         col <= nxt_col;
         row <= nxt_row;
         if (nxt_col == CW'(W - 1)) begin
            nxt_col <= '0;
            nxt_row <= (nxt_row == RW'(H - 1)) ? '0 : nxt_row + RW'(1);
         end else begin
            nxt_col <= nxt_col + CW'(1);
         end
      end
   end

   // NOTE: every signal in this block is assigned on every path, so no latch can be inferred.
   always_comb begin
      pos_sum = SW'(t00) + {1'b0, t220, 1'b0} + SW'(t440);
      neg_sum = SW'(t02) + {1'b0, t222, 1'b0} + SW'(t442);
      gx      = $signed({1'b0, pos_sum}) - $signed({1'b0, neg_sum});
      gx_abs  = gx[GW-1] ? $unsigned(-gx) : $unsigned(gx);
      gx_sat  = (gx_abs > GW'({DW{1'b1}})) ? '1 : gx_abs[DW-1:0];
      win_ok  = (row >= RW'(2)) && (col >= CW'(2));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pxl_out    <= '0;
         valid      <= 1'b0;
         test_valid <= '0;
      end else begin
         pxl_out <= gx_sat;
         valid   <= win_ok;
         if (valid && (test_valid != 16'hFFFF)) test_valid <= test_valid + 16'd1;
      end
   end

   assign reg_00  = {{DW{1'b0}}, t00};
   assign reg_01  = {{DW{1'b0}}, t01};
   assign reg_02  = {{DW{1'b0}}, t02};
   assign sr_0    = {{DW{1'b0}}, dl0[DL-1]};
   assign reg_220 = {{DW{1'b0}}, t220};
   assign reg_221 = {{DW{1'b0}}, t221};
   assign reg_222 = {{DW{1'b0}}, t222};
   assign sr_1    = {{DW{1'b0}}, dl1[DL-1]};
   assign reg_440 = {{DW{1'b0}}, t440};
   assign reg_441 = {{DW{1'b0}}, t441};
   assign reg_442 = {{DW{1'b0}}, t442};
   assign test    = 8'(col);

endmodule

// File: tb/tb_conv_3x3.sv
// Bench for conv_3x3. It streams one banded frame, the start of a back-to-back frame, and a post-reset frame.
// Each output is compared with a 2-D Sobel model and with hand-computed spot values.
module tb_conv_3x3;

   localparam int W = 220;
   localparam int H = 220;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  pxl_in = 8'd0;
   logic [15:0] reg_00, reg_01, reg_02, sr_0, reg_220, reg_221, reg_222;
   logic [15:0] sr_1, reg_440, reg_441, reg_442, test_valid;
   logic [7:0]  pxl_out, test;
   logic        valid;

   always #5 clk = ~clk;

   conv_3x3 #(.W(W), .H(H), .DW(8)) dut (
      .clk(clk), .reset(rst_n), .pxl_in(pxl_in),
      .reg_00(reg_00), .reg_01(reg_01), .reg_02(reg_02), .sr_0(sr_0),
      .reg_220(reg_220), .reg_221(reg_221), .reg_222(reg_222), .sr_1(sr_1),
      .reg_440(reg_440), .reg_441(reg_441), .reg_442(reg_442),
      .pxl_out(pxl_out), .valid(valid), .test(test), .test_valid(test_valid)
   );

   typedef struct { bit live; int f; int r; int c; logic [7:0] pix; } ent_t;
   typedef struct { int r; int c; int exp_out; } spot_t;

   int    checks = 0;
   int    failures = 0;
   int    edge_cnt, exp_vcnt, dut_vcnt, sweep_err, spot_hits, first_valid_edge;
   ent_t  pipe0, pipe1;
   spot_t spots[18];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp_v);
      end
   endtask

   // Frame 0 has bands of rows: constant, ramp, reverse ramp, then step. Frame 1 is a ramp; frame 2 is a gentle gradient.
   function automatic int pix(input int f, input int r, input int c);
      int v;
      if (f == 0) begin
         if (r < 60)       v = 100;
         else if (r < 120) v = c;
         else if (r < 180) v = 219 - c;
         else              v = (c < 110) ? 0 : 255;
      end else if (f == 1) begin
         v = c;
      end else begin
         v = (c + 5*r + 1) % 256;
      end
      return v;
   endfunction

   function automatic int sob(input int f, input int r, input int c);
      int g;
      g = (pix(f, r-2, c) - pix(f, r-2, c-2)) + 2*(pix(f, r-1, c) - pix(f, r-1, c-2))
        + (pix(f, r, c) - pix(f, r, c-2));
      if (g < 0) g = -g;
      return (g > 255) ? 255 : g;
   endfunction

   task automatic observe();
      bit exp_valid;
      exp_valid = pipe1.live && (pipe1.r >= 2) && (pipe1.c >= 2);
      if (valid !== exp_valid) sweep_err++;
      if (exp_valid && (pxl_out !== 8'(sob(pipe1.f, pipe1.r, pipe1.c)))) sweep_err++;
      if (test_valid !== 16'(exp_vcnt)) sweep_err++;
      if (pipe0.live) begin
         if (reg_00 !== {8'h00, pipe0.pix}) sweep_err++;
         if (test !== 8'(pipe0.c)) sweep_err++;
      end
      if (exp_valid && pipe1.f == 0) begin
         for (int i = 0; i < 18; i++) begin
            if (spots[i].r == pipe1.r && spots[i].c == pipe1.c) begin
               check($sformatf("spot_r%0d_c%0d", pipe1.r, pipe1.c), 32'(pxl_out), 32'(spots[i].exp_out));
               spot_hits++;
            end
         end
      end
      if (valid === 1'b1) begin
         dut_vcnt++;
         if (first_valid_edge < 0) first_valid_edge = edge_cnt;
      end
      if (exp_valid) exp_vcnt++;
   endtask

   // Entered at a negedge: check the current outputs, drive the next pixel, then advance one clock.
   task automatic cycle(input int f, input int r, input int c);
      int p;
      observe();
      p = pix(f, r, c);
      pxl_in = 8'(p);
      pipe1 = pipe0;
      pipe0 = '{live: 1'b1, f: f, r: r, c: c, pix: 8'(p)};
      @(negedge clk);
      edge_cnt++;
   endtask

   task automatic hold_reset(input int n, input string tag);
      rst_n = 1'b0;
      for (int k = 0; k < n; k++) begin
         #1;
         check($sformatf("%s_all_zero_%0d", tag, k),
               32'(|{reg_00, reg_01, reg_02, sr_0, reg_220, reg_221, reg_222, sr_1,
                     reg_440, reg_441, reg_442, pxl_out, valid, test, test_valid}), 32'd0);
         @(negedge clk);
      end
      rst_n = 1'b1;
      pipe0 = '{live: 1'b0, f: 0, r: 0, c: 0, pix: 8'd0};
      pipe1 = pipe0;
      edge_cnt = 0;
      exp_vcnt = 0;
      dut_vcnt = 0;
      first_valid_edge = -1;
   endtask

   initial begin
      spots = '{
         '{2, 2, 0},     '{59, 219, 0},   '{60, 5, 2},     '{61, 5, 6},
         '{62, 5, 8},    '{100, 219, 8},  '{120, 10, 4},   '{121, 10, 4},
         '{122, 10, 8},  '{150, 2, 8},    '{180, 110, 249}, '{180, 50, 6},
         '{181, 111, 255}, '{181, 112, 2}, '{182, 110, 255}, '{182, 111, 255},
         '{182, 112, 0}, '{219, 109, 0}
      };
      sweep_err = 0;
      spot_hits = 0;

      hold_reset(3, "init_reset");
      check("init_test_valid", 32'(test_valid), 32'd0);

      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++)
            cycle(0, r, c);

      // Frame 1 follows back-to-back; frame 0's totals are settled by row 1.
      for (int idx = 0; idx < 4*W + 50; idx++) begin
         if (idx == W + 100) begin
            check("test_valid_after_frame0", 32'(test_valid), 32'd47524);
            check("valid_count_frame0", 32'(dut_vcnt), 32'd47524);
         end
         cycle(1, idx / W, idx % W);
      end
      check("frame01_sweep_errors", 32'(sweep_err), 32'd0);
      check("spot_hits", 32'(spot_hits), 32'd18);
      sweep_err = 0;

      hold_reset(3, "mid_reset");
      for (int idx = 0; idx < 700; idx++) begin
         if (idx == 219) check("sr_0_before_edge220", 32'(sr_0), 32'd0);
         if (idx == 220) check("sr_0_after_edge220", 32'(sr_0), 32'd1);
         if (idx == 442) check("reg_442_before_edge443", 32'(reg_442), 32'd0);
         if (idx == 443) begin
            check("reg_442_after_edge443", 32'(reg_442), 32'd1);
            check("valid_low_after_edge443", 32'(valid), 32'd0);
         end
         if (idx == 444) check("valid_high_after_edge444", 32'(valid), 32'd1);
         cycle(2, idx / W, idx % W);
      end
      check("first_valid_edge", 32'(first_valid_edge), 32'd444);
      check("frame2_sweep_errors", 32'(sweep_err), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
